// File: rtl/unidade_controle_mc.sv
// -----------------------------------------------------------------------------
// unidade_controle_mc
// Multicycle control FSM for the 8-bit CPU. It steps each instruction through
// FETCH / DECODE / EXECUTE / MEM / WRITEBACK. It drives the datapath enables
// and the next-PC select, handshakes with a variable-latency memory, and traps
// into HALT on an illegal opcode or on a memory timeout.
//
// Parameters
//   MEM_TIMEOUT  cycles a memory request may wait for mem_pronto (1..255)
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   habilita    in   run enable, only looked at in FETCH
//   opcode[3:0] in   IR[7:4], valid from DECODE onward
//   zero        in   ALU zero flag, used in BRANCH
//   mem_pronto  in   memory finishes the current access this cycle
//   EscPC       out  PC write enable
//   FontePC[1:0] out next-PC select: 00 PC+1, 01 branch target, 10 jump target
//   EscIR       out  IR write enable
//   EscReg      out  register file write enable
//   MemParaReg  out  writeback source: 0 ALU, 1 memory data
//   LerMem      out  memory read request
//   EscMem      out  memory write request
//   IouD        out  memory address source: 0 PC, 1 ALU result
//   ALUOp[2:0]  out  000 ADD, 001 SUB, 010 AND, 011 OR
//   parado      out  FSM is in HALT
//   erro        out  sticky trap flag
//   estado[3:0] out  current state code, for debug
//
// state    | meaning
// FETCH    | read instruction at PC, load IR, PC <= PC+1 (code 0)
// DECODE   | pick the instruction path from opcode (code 1)
// EXEC_ALU | ALU performs the register operation (code 2)
// WB_ALU   | ALU result written to the register file (code 3)
// MEM_ADDR | ALU computes the data address (code 4)
// MEM_RD   | data read, waits for mem_pronto (code 5)
// WB_MEM   | memory data written to the register file (code 6)
// MEM_WR   | data write, waits for mem_pronto (code 7)
// BRANCH   | compare and conditionally take the branch target (code 8)
// JUMP     | unconditional PC load from the jump target (code 9)
// HALT     | stopped; only reset_n leaves this state (code 15)
// -----------------------------------------------------------------------------
module unidade_controle_mc #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       habilita,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_pronto,
  output logic       EscPC,
  output logic [1:0] FontePC,
  output logic       EscIR,
  output logic       EscReg,
  output logic       MemParaReg,
  output logic       LerMem,
  output logic       EscMem,
  output logic       IouD,
  output logic [2:0] ALUOp,
  output logic       parado,
  output logic       erro,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_ALU = 4'd2,
    S_WB_ALU   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       erro_q, erro_d;

  logic wait_st;
  logic tmo;

  // A FETCH with habilita low issues no request, so it is not a wait state.
  assign wait_st = ((state_q == S_FETCH) && habilita) ||
                   (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Completion in the same cycle as the limit wins over the trap.
  assign tmo     = wait_st && !mem_pronto && (cnt_q == TMO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    erro_d  = erro_q;
    unique case (state_q)
      S_FETCH: begin
        if (habilita) begin
          if (tmo) begin
            state_d = S_HALT;
            erro_d  = 1'b1;
          end else if (mem_pronto) begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        unique case (opcode)
          4'b0000:                            state_d = S_FETCH;
          4'b0001, 4'b0010, 4'b0011, 4'b0100: state_d = S_EXEC_ALU;
          4'b0101, 4'b0110:                   state_d = S_MEM_ADDR;
          4'b0111:                            state_d = S_BRANCH;
          4'b1000:                            state_d = S_JUMP;
          4'b1111:                            state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            erro_d  = 1'b1;
          end
        endcase
      end
      S_EXEC_ALU: state_d = S_WB_ALU;
      S_WB_ALU:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == 4'b0110) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (tmo) begin
          state_d = S_HALT;
          erro_d  = 1'b1;
        end else if (mem_pronto) begin
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (tmo) begin
          state_d = S_HALT;
          erro_d  = 1'b1;
        end else if (mem_pronto) begin
          state_d = S_FETCH;
        end
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts whenever a new state is entered and only runs
  // while an issued request is still outstanding.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_FETCH) && !habilita) begin
      cnt_d = '0;
    end else if (wait_st && !mem_pronto) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    EscPC      = 1'b0;
    FontePC    = 2'b00;
    EscIR      = 1'b0;
    EscReg     = 1'b0;
    MemParaReg = 1'b0;
    LerMem     = 1'b0;
    EscMem     = 1'b0;
    IouD       = 1'b0;
    ALUOp      = 3'b000;
    parado     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (habilita && !tmo) begin
          LerMem = 1'b1;
          EscIR  = mem_pronto;
          EscPC  = mem_pronto;
        end
      end
      S_EXEC_ALU, S_WB_ALU: begin
        ALUOp  = 3'(opcode - 4'd1);
        EscReg = (state_q == S_WB_ALU);
      end
      S_MEM_RD: begin
        if (!tmo) begin
          LerMem = 1'b1;
          IouD   = 1'b1;
        end
      end
      S_WB_MEM: begin
        EscReg     = 1'b1;
        MemParaReg = 1'b1;
      end
      S_MEM_WR: begin
        if (!tmo) begin
          EscMem = 1'b1;
          IouD   = 1'b1;
        end
      end
      S_BRANCH: begin
        ALUOp   = 3'b001;
        EscPC   = zero;
        FontePC = 2'b01;
      end
      S_JUMP: begin
        EscPC   = 1'b1;
        FontePC = 2'b10;
      end
      S_HALT:  parado = 1'b1;
      default: ;
    endcase
  end

  assign erro   = erro_q;
  assign estado = state_q;

endmodule

// File: tb/tb_unidade_controle_mc.sv
module tb_unidade_controle_mc;

  logic       clk;
  logic       reset_n;
  logic       habilita;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_pronto;
  logic       EscPC;
  logic [1:0] FontePC;
  logic       EscIR;
  logic       EscReg;
  logic       MemParaReg;
  logic       LerMem;
  logic       EscMem;
  logic       IouD;
  logic [2:0] ALUOp;
  logic       parado;
  logic       erro;
  logic [3:0] estado;

  unidade_controle_mc #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .habilita   (habilita),
    .opcode     (opcode),
    .zero       (zero),
    .mem_pronto (mem_pronto),
    .EscPC      (EscPC),
    .FontePC    (FontePC),
    .EscIR      (EscIR),
    .EscReg     (EscReg),
    .MemParaReg (MemParaReg),
    .LerMem     (LerMem),
    .EscMem     (EscMem),
    .IouD       (IouD),
    .ALUOp      (ALUOp),
    .parado     (parado),
    .erro       (erro),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {EscPC, FontePC, EscIR, EscReg, MemParaReg, LerMem, EscMem, IouD,
  //  ALUOp, parado, erro, estado}
  logic [17:0] act;
  assign act = {EscPC, FontePC, EscIR, EscReg, MemParaReg, LerMem, EscMem,
                IouD, ALUOp, parado, erro, estado};

  typedef struct {
    logic        hab;
    logic [3:0]  op;
    logic        z;
    logic        mp;
    logic [17:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [17:0] o(input logic [3:0] st, input logic pc,
                                    input logic [1:0] fp, input logic ir,
                                    input logic rg, input logic mr,
                                    input logic lm, input logic em,
                                    input logic io, input logic [2:0] alu,
                                    input logic pa, input logic er);
    return {pc, fp, ir, rg, mr, lm, em, io, alu, pa, er, st};
  endfunction

  task automatic add(input logic hab, input logic [3:0] op, input logic z,
                     input logic mp, input logic [17:0] exp);
    vec_t v;
    v.hab = hab; v.op = op; v.z = z; v.mp = mp; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [17:0] a,
                     input logic [17:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b (estado=%0d) want %b (estado=%0d)",
               name, a, a[3:0], e, e[3:0]);
    end
  endtask

  // Scoreboard: expectations queued when the stimulus is applied are
  // checked mid-cycle, after the Mealy outputs have settled.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t s;
      s = sb_q.pop_front();
      cmp(s.name, act, s.exp);
    end
  end

  task automatic step(input string name, input logic hab, input logic [3:0] op,
                      input logic z, input logic mp, input logic [17:0] exp);
    sb_t s;
    @(posedge clk);
    #1;
    habilita = hab; opcode = op; zero = z; mem_pronto = mp;
    s.name = name; s.exp = exp;
    sb_q.push_back(s);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    habilita = 1'b0; opcode = 4'h0; zero = 1'b0; mem_pronto = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  localparam logic [17:0] HALT_ERR = 18'b0_00_0_0_0_0_0_0_000_1_1_1111;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; habilita = 1'b0; opcode = 4'h0; zero = 1'b0;
    mem_pronto = 1'b0;
    #3;
    cmp("reset_state", act, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    #9;
    reset_n = 1'b1;

    // ADD zero-wait: 0,1,2,3
    add(1,4'h1,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h1,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h1,0,1, o(2, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h1,0,1, o(3, 0,2'b00,0,1,0,0,0,0,3'd0,0,0));
    // SUB
    add(1,4'h2,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h2,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h2,0,1, o(2, 0,2'b00,0,0,0,0,0,0,3'd1,0,0));
    add(1,4'h2,0,1, o(3, 0,2'b00,0,1,0,0,0,0,3'd1,0,0));
    // OR
    add(1,4'h4,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h4,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h4,0,1, o(2, 0,2'b00,0,0,0,0,0,0,3'd3,0,0));
    add(1,4'h4,0,1, o(3, 0,2'b00,0,1,0,0,0,0,3'd3,0,0));
    // NOP
    add(1,4'h0,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h0,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    // LOAD, memory ready after 3 wait cycles in MEM_RD
    add(1,4'h5,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h5,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h5,0,1, o(4, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h5,0,0, o(5, 0,2'b00,0,0,0,1,0,1,3'd0,0,0));
    add(1,4'h5,0,0, o(5, 0,2'b00,0,0,0,1,0,1,3'd0,0,0));
    add(1,4'h5,0,0, o(5, 0,2'b00,0,0,0,1,0,1,3'd0,0,0));
    add(1,4'h5,0,1, o(5, 0,2'b00,0,0,0,1,0,1,3'd0,0,0));
    add(1,4'h5,0,1, o(6, 0,2'b00,0,1,1,0,0,0,3'd0,0,0));
    // FETCH with one wait cycle, then BEQ taken
    add(1,4'h7,1,0, o(0, 0,2'b00,0,0,0,1,0,0,3'd0,0,0));
    add(1,4'h7,1,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h7,1,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h7,1,1, o(8, 1,2'b01,0,0,0,0,0,0,3'd1,0,0));
    // BEQ not taken
    add(1,4'h7,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h7,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h7,0,1, o(8, 0,2'b01,0,0,0,0,0,0,3'd1,0,0));
    // JMP
    add(1,4'h8,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h8,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h8,0,1, o(9, 1,2'b10,0,0,0,0,0,0,3'd0,0,0));
    // STORE zero-wait
    add(1,4'h6,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'h6,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h6,0,1, o(4, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'h6,0,1, o(7, 0,2'b00,0,0,0,0,1,1,3'd0,0,0));
    // idle with habilita low, mem_pronto ignored
    add(0,4'h1,0,1, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(0,4'h1,0,1, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    // illegal opcode 1010 traps and sticks
    add(1,4'hA,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    add(1,4'hA,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    add(1,4'hA,0,1, HALT_ERR);
    add(1,4'h1,1,1, HALT_ERR);
    add(1,4'h0,1,1, HALT_ERR);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].hab, vecs[i].op, vecs[i].z,
           vecs[i].mp, vecs[i].exp);

    // MEM_WR timeout: 15 request cycles, one silent cycle, then HALT
    do_reset();
    cmp("halt_cleared_by_reset", act, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("tmo_fetch", 1,4'h6,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    step("tmo_dec",   1,4'h6,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("tmo_addr",  1,4'h6,0,1, o(4, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    for (int k = 0; k < 15; k++)
      step($sformatf("tmo_wr%0d", k), 1,4'h6,0,0,
           o(7, 0,2'b00,0,0,0,0,1,1,3'd0,0,0));
    step("tmo_limit", 1,4'h6,0,0, o(7, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("tmo_halt",  1,4'h6,0,1, HALT_ERR);
    step("tmo_stuck", 1,4'h6,0,1, HALT_ERR);

    // completion exactly at the limit wins over the trap
    do_reset();
    step("lim_fetch", 1,4'h6,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    step("lim_dec",   1,4'h6,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("lim_addr",  1,4'h6,0,1, o(4, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    for (int k = 0; k < 15; k++)
      step($sformatf("lim_wr%0d", k), 1,4'h6,0,0,
           o(7, 0,2'b00,0,0,0,0,1,1,3'd0,0,0));
    step("lim_done",  1,4'h6,0,1, o(7, 0,2'b00,0,0,0,0,1,1,3'd0,0,0));
    step("lim_back",  1,4'h1,0,0, o(0, 0,2'b00,0,0,0,1,0,0,3'd0,0,0));

    // async reset in the middle of a read wait
    do_reset();
    step("rst_fetch", 1,4'h5,0,1, o(0, 1,2'b00,1,0,0,1,0,0,3'd0,0,0));
    step("rst_dec",   1,4'h5,0,1, o(1, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("rst_addr",  1,4'h5,0,1, o(4, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("rst_rd",    1,4'h5,0,0, o(5, 0,2'b00,0,0,0,1,0,1,3'd0,0,0));
    reset_n = 1'b0;
    habilita = 1'b0;
    #1;
    cmp("rst_async", act, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    #1;
    reset_n = 1'b1;
    step("idle0", 0,4'h5,0,1, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("idle1", 0,4'h5,0,0, o(0, 0,2'b00,0,0,0,0,0,0,3'd0,0,0));
    step("resume", 1,4'h5,0,0, o(0, 0,2'b00,0,0,0,1,0,0,3'd0,0,0));

    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle_mc.md
Name: unidade_controle_mc

Overview:
- Multicycle control FSM for the 8-bit CPU. It sequences the program counter, instruction register, register file, ALU and memory port across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Generates the PC write enable (EscPC) and next-PC source select consumed by the PC register.
- Handshakes with a variable-latency memory and traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15, max cycles a memory request may wait for mem_pronto before trapping (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- habilita  input  1  run enable, sampled only in FETCH.
- opcode  input  4  IR[7:4], valid from DECODE onward.
- zero  input  1  ALU zero flag, valid in BRANCH.
- mem_pronto  input  1  memory completes the current read/write this cycle.
- EscPC  output  1  PC write enable.
- FontePC  output  2  next-PC select: 00 PC+1, 01 branch target, 10 jump target.
- EscIR  output  1  IR write enable.
- EscReg  output  1  register file write enable.
- MemParaReg  output  1  writeback source: 0 ALU, 1 memory data.
- LerMem  output  1  memory read request.
- EscMem  output  1  memory write request.
- IouD  output  1  memory address source: 0 PC, 1 ALU result.
- ALUOp  output  3  000 ADD, 001 SUB, 010 AND, 011 OR.
- parado  output  1  FSM in HALT.
- erro  output  1  sticky trap flag.
- estado  output  4  current state code, for debug.

Behaviour:
- Reset (async, reset_n=0): state FETCH, wait counter 0, erro 0. Outputs in FETCH are defined below; they go 0 while habilita=0.
- Outputs are decoded from state; some also depend on mem_pronto or zero (Mealy). Any output not listed for a state is 0.
- State codes: FETCH 0, DECODE 1, EXEC_ALU 2, WB_ALU 3, MEM_ADDR 4, MEM_RD 5, WB_MEM 6, MEM_WR 7, BRANCH 8, JUMP 9, HALT 15.
- FETCH:
  - habilita=0: no request, remain in FETCH.
  - Else: LerMem=1, IouD=0, EscIR=mem_pronto, EscPC=mem_pronto, FontePC=00.
  - On mem_pronto: go to DECODE.
- DECODE: 1 cycle, ALUOp=ADD. Next state by opcode:
  - 0000 NOP: FETCH.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: EXEC_ALU.
  - 0101 LOAD, 0110 STORE: MEM_ADDR.
  - 0111 BEQ: BRANCH.
  - 1000 JMP: JUMP.
  - 1111 HALT: HALT.
  - Any other opcode: erro<=1, HALT.
- EXEC_ALU: ALUOp = opcode-1 (ADD 000 … OR 011); go to WB_ALU.
- WB_ALU: EscReg=1, MemParaReg=0, ALUOp held; go to FETCH.
- MEM_ADDR: ALUOp=ADD; go to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: LerMem=1, IouD=1, ALUOp=ADD held; on mem_pronto go to WB_MEM.
- WB_MEM: EscReg=1, MemParaReg=1; go to FETCH.
- MEM_WR: EscMem=1, IouD=1, ALUOp=ADD held; on mem_pronto go to FETCH.
- BRANCH: ALUOp=SUB, EscPC=zero, FontePC=01; go to FETCH.
- JUMP: EscPC=1, FontePC=10; go to FETCH.
- HALT: parado=1, all enables 0; exits only via reset_n.
- Memory wait and timeout (FETCH with habilita=1, MEM_RD, MEM_WR):
  - Counter clears on entry to each wait state and increments every cycle without mem_pronto.
  - When the counter reaches MEM_TIMEOUT with mem_pronto still 0: erro<=1, go to HALT, no enable asserted that cycle.
  - mem_pronto in the same cycle the count reaches MEM_TIMEOUT: completion wins.
- LerMem and EscMem are never both 1. EscPC and EscReg are never both 1.
- Requests stay asserted and stable until mem_pronto; mem_pronto outside a wait state is ignored.
- Latency with zero-wait memory (mem_pronto=1 every cycle): NOP 2, ALU 4, LOAD 5, STORE 4, BEQ 3, JMP 3 cycles.
- Reset mid-operation returns to FETCH immediately and clears erro; an in-flight memory request is dropped asynchronously.

Test Plan:
- Zero-wait ADD (opcode 0001): estado sequence 0,1,2,3,0. EscPC=1 only in FETCH; EscReg=1 in state 3 with ALUOp=000.
- LOAD with mem_pronto delayed 3 cycles in MEM_RD: LerMem=1, IouD=1 held 4 cycles. Then WB_MEM asserts EscReg=1, MemParaReg=1. Total 8 cycles.
- BEQ: with zero=1, EscPC=1 and FontePC=01 in BRANCH. With zero=0, EscPC=0 and the next FETCH address is unchanged.
- JMP (1000): EscPC=1, FontePC=10 in JUMP. Opcode 1010: erro=1, parado=1, estado=15, stuck until reset_n.
- Timeout with MEM_TIMEOUT=15 and mem_pronto held 0 in MEM_WR: EscMem=1 for 15 cycles, then HALT with erro=1. Also drive mem_pronto=1 exactly at cycle 15: completes normally to FETCH.
- reset_n pulsed low mid-MEM_RD: outputs drop immediately, estado=0, erro=0. habilita=0 after reset: FSM idles in FETCH with LerMem=0.
